// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: reset address,
// state encoding and the sequential fetch increment.
package pc_gen_pkg;

    // Default first fetch address after reset.
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // Sequential fetch stride in bytes.
    localparam logic [63:0] PC_INCR = 64'd4;

    // Front-end states, kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Fetch addresses are word aligned, so the low two bits of any loaded
    // target are dropped.
    function automatic logic [63:0] align_target(input logic [63:0] target);
        return {target[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// One-entry pending buffer for redirects that arrive while fetch cannot
// advance, plus the trap-over-redirect priority mux. The selected target is
// the newest event when one is present this cycle, otherwise the held entry.
module pc_redirect_hold
    import pc_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trap_valid_i,
    input  logic [63:0] trap_target_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_target_i,
    input  logic        capture_i,
    input  logic        release_i,
    output logic [63:0] target_o,
    output logic        event_o,
    output logic        pending_valid_o
);

    logic [63:0] pending_q;
    logic        pending_valid_q;
    logic [63:0] new_target;

    // Trap beats redirect; the newest event beats anything already held.
    always_comb begin
        new_target = trap_valid_i ? align_target(trap_target_i)
                                  : align_target(redirect_target_i);
        event_o    = trap_valid_i | redirect_valid_i;
        target_o   = event_o ? new_target : pending_q;
    end

    // Capture a deferred target, or drop the valid flag once it is consumed.
    // NOTE: the target payload is reset too so that a reset in HOLD can
    // never leave a stale address that a later path might expose.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
        end else if (capture_i) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so ordering inside the block does not matter.
            pending_q       <= new_target;
            pending_valid_q <= 1'b1;
        end else if (release_i) begin
            pending_valid_q <= 1'b0;
        end
    end

    assign pending_valid_o = pending_valid_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the front end. Owns the fetch address and
// fetch enable, advances by 4 when fetch and pipeline allow, and applies
// branch and trap redirects without ever changing the address mid-fetch.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        stall_global,
    input  logic        stall_from_inst_if,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        trap_valid,
    input  logic [63:0] trap_target,
    output logic [63:0] inst_address,
    output logic        ce,
    output logic        fetch_kill
);

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        kill_q, kill_d;

    logic        adv;
    logic        evt;
    logic        capture;
    logic        release_pend;
    logic        pending_valid;
    logic [63:0] sel_target;

    assign adv = !stall_global && !stall_from_inst_if;

    // Defer an event only once running; sources are quiescent in BOOT.
    assign capture      = (state_q != ST_BOOT) && evt && !adv;
    assign release_pend = (state_q == ST_HOLD) && adv;

    pc_redirect_hold u_hold (
        .clk_i             (ACLK),
        .rst_ni            (ARESETn),
        .trap_valid_i      (trap_valid),
        .trap_target_i     (trap_target),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .capture_i         (capture),
        .release_i         (release_pend),
        .target_o          (sel_target),
        .event_o           (evt),
        .pending_valid_o   (pending_valid)
    );

    // Next-state, next-PC and output decode for the front-end state machine.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        kill_d  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                ce_d    = 1'b1;
            end
            ST_RUN: begin
                ce_d = 1'b1;
                if (adv) begin
                    if (evt) begin
                        pc_d   = sel_target;
                        kill_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_INCR;
                    end
                end else if (evt) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                ce_d = 1'b1;
                if (adv && (pending_valid || evt)) begin
                    pc_d    = sel_target;
                    kill_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                ce_d    = 1'b0;
            end
        endcase
    end

    // State, PC and registered fetch controls.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ce_q    <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            kill_q  <= kill_d;
        end
    end

    assign inst_address = pc_q;
    assign ce           = ce_q;
    assign fetch_kill   = kill_q;

endmodule
